// File: rtl/stage_sequencer.sv
//------------------------------------------------------------------------------
// Module      : stage_sequencer
// Description : Game stage flow controller (idle/intro/play/clear/won/lost).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stage_sequencer #(
    parameter int INTRO_FRAMES = 60,
    parameter int CLEAR_FRAMES = 90,
    parameter int LAST_STAGE   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       start_game,
    input  logic       pause,
    input  logic       all_monsters_dead,
    input  logic       player_dead,
    output logic [2:0] stage_num,
    output logic       stage_load,
    output logic       monsters_enable,
    output logic       banner_on,
    output logic       game_won,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTRO = 3'd1,
        S_PLAY  = 3'd2,
        S_CLEAR = 3'd3,
        S_WON   = 3'd4,
        S_LOST  = 3'd5
    } state_t;

    localparam logic [7:0] C_INTRO_LAST = 8'(INTRO_FRAMES - 1);
    localparam logic [7:0] C_CLEAR_LAST = 8'(CLEAR_FRAMES - 1);
    localparam logic [2:0] C_LAST_STAGE = 3'(LAST_STAGE);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [2:0] w_stage_next;

    always_comb begin
        w_next       = r_state;
        w_cnt_next   = r_cnt;
        w_stage_next = stage_num;
        case (r_state)
            S_IDLE, S_WON, S_LOST: begin
                if (start_game) begin
                    w_next       = S_INTRO;
                    w_stage_next = 3'd1;
                end
            end
            S_INTRO: begin
                if (startOfFrame) begin
                    if (r_cnt == C_INTRO_LAST) w_next = S_PLAY;
                    else                       w_cnt_next = r_cnt + 8'd1;
                end
            end
            S_PLAY: begin
                // Losing the last life wins over a simultaneous clear.
                if (player_dead)            w_next = S_LOST;
                else if (all_monsters_dead) w_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (startOfFrame) begin
                    if (r_cnt == C_CLEAR_LAST) begin
                        if (stage_num == C_LAST_STAGE) begin
                            w_next = S_WON;
                        end else begin
                            w_next       = S_INTRO;
                            w_stage_next = stage_num + 3'd1;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 8'd1;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
        // A frame pulse that causes a transition is not counted in the new state.
        if (w_next != r_state) w_cnt_next = 8'd0;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= 8'd0;
            stage_num       <= 3'd0;
            stage_load      <= 1'b0;
            monsters_enable <= 1'b0;
            banner_on       <= 1'b0;
            game_won        <= 1'b0;
            game_over       <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_cnt           <= w_cnt_next;
            stage_num       <= w_stage_next;
            stage_load      <= (w_next == S_INTRO) && (r_state != S_INTRO);
            monsters_enable <= (w_next == S_PLAY) && !pause;
            banner_on       <= (w_next == S_INTRO);
            game_won        <= (w_next == S_WON);
            game_over       <= (w_next == S_LOST);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_stage_sequencer.sv
//------------------------------------------------------------------------------
// Module      : tb_stage_sequencer
// Description : Directed self-checking bench for stage_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       sof;
    logic       start_game;
    logic       pause;
    logic       amd;
    logic       pd;
    logic [2:0] stage_num;
    logic       stage_load;
    logic       monsters_enable;
    logic       banner_on;
    logic       game_won;
    logic       game_over;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] stage;
        logic       load;
        logic       me;
        logic       ban;
        logic       won;
        logic       over;
    } exp_t;

    exp_t sb[$];

    stage_sequencer #(
        .INTRO_FRAMES(2),
        .CLEAR_FRAMES(3),
        .LAST_STAGE  (4)
    ) dut (
        .clk              (clk),
        .reset            (rst),
        .startOfFrame     (sof),
        .start_game       (start_game),
        .pause            (pause),
        .all_monsters_dead(amd),
        .player_dead      (pd),
        .stage_num        (stage_num),
        .stage_load       (stage_load),
        .monsters_enable  (monsters_enable),
        .banner_on        (banner_on),
        .game_won         (game_won),
        .game_over        (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_one(input string tag, input string field,
                             input logic [2:0] obs, input logic [2:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic pop_and_check();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard observed empty expected entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_one(e.tag, "stage_num",       stage_num,             e.stage);
            check_one(e.tag, "stage_load",      {2'b0, stage_load},      {2'b0, e.load});
            check_one(e.tag, "monsters_enable", {2'b0, monsters_enable}, {2'b0, e.me});
            check_one(e.tag, "banner_on",       {2'b0, banner_on},       {2'b0, e.ban});
            check_one(e.tag, "game_won",        {2'b0, game_won},        {2'b0, e.won});
            check_one(e.tag, "game_over",       {2'b0, game_over},       {2'b0, e.over});
        end
    endtask

    // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
    task automatic step(input string tag,
                        input logic i_rst, input logic i_sof, input logic i_start,
                        input logic i_pause, input logic i_amd, input logic i_pd,
                        input logic [2:0] e_stage, input logic e_load, input logic e_me,
                        input logic e_ban, input logic e_won, input logic e_over);
        exp_t e;
        rst        = i_rst;
        sof        = i_sof;
        start_game = i_start;
        pause      = i_pause;
        amd        = i_amd;
        pd         = i_pd;
        e.tag = tag; e.stage = e_stage; e.load = e_load; e.me = e_me;
        e.ban = e_ban; e.won = e_won; e.over = e_over;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check();
    endtask

    task automatic intro_to_play(input logic [2:0] n);
        step("intro_f1", 0, 1, 0, 0, 0, 0, n, 0, 0, 1, 0, 0);
        step("intro_f2", 0, 1, 0, 0, 0, 0, n, 0, 1, 0, 0, 0);
    endtask

    task automatic clear_stage(input logic [2:0] n);
        step("clear_enter", 0, 0, 0, 0, 1, 0, n, 0, 0, 0, 0, 0);
        step("clear_f1",    0, 1, 0, 0, 1, 0, n, 0, 0, 0, 0, 0);
        step("clear_f2",    0, 1, 0, 0, 0, 0, n, 0, 0, 0, 0, 0);
        step("clear_start", 0, 0, 1, 0, 0, 0, n, 0, 0, 0, 0, 0);
        if (n == 3'd4)
            step("clear_won", 0, 1, 0, 0, 0, 0, 3'd4, 0, 0, 0, 1, 0);
        else
            step("clear_next", 0, 1, 0, 0, 0, 0, n + 3'd1, 1, 0, 1, 0, 0);
    endtask

    initial begin
        rst = 1'b1; sof = 1'b0; start_game = 1'b0; pause = 1'b0; amd = 1'b0; pd = 1'b0;

        step("reset",      1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        step("idle",       0, 1, 0, 1, 1, 1, 3'd0, 0, 0, 0, 0, 0);
        step("start",      0, 0, 1, 0, 0, 0, 3'd1, 1, 0, 1, 0, 0);
        step("intro_hold", 0, 0, 1, 0, 1, 1, 3'd1, 0, 0, 1, 0, 0);
        intro_to_play(3'd1);
        step("play",       0, 0, 1, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0);

        step("pause_rise", 0, 0, 0, 1, 0, 0, 3'd1, 0, 0, 0, 0, 0);
        for (int f = 0; f < 5; f++)
            step("pause_hold", 0, 1, 0, 1, 0, 0, 3'd1, 0, 0, 0, 0, 0);
        step("pause_fall", 0, 0, 0, 0, 0, 0, 3'd1, 0, 1, 0, 0, 0);

        clear_stage(3'd1);
        step("intro2_idle", 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 1, 0, 0);
        for (int s = 2; s <= 4; s++) begin
            intro_to_play(3'(s));
            clear_stage(3'(s));
        end

        step("won_hold",    0, 1, 0, 0, 1, 1, 3'd4, 0, 0, 0, 1, 0);
        step("won_restart", 0, 0, 1, 0, 0, 0, 3'd1, 1, 0, 1, 0, 0);
        intro_to_play(3'd1);

        step("lost_both",   0, 0, 0, 0, 1, 1, 3'd1, 0, 0, 0, 0, 1);
        step("lost_amd",    0, 1, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 1);
        step("lost_restart",0, 0, 1, 0, 0, 0, 3'd1, 1, 0, 1, 0, 0);
        intro_to_play(3'd1);

        step("rc_enter",    0, 0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0, 0);
        step("rc_f1",       0, 1, 0, 0, 0, 0, 3'd1, 0, 0, 0, 0, 0);
        step("rc_reset",    1, 1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        step("rc_after",    0, 1, 0, 0, 1, 0, 3'd0, 0, 0, 0, 0, 0);
        step("rc_restart",  0, 0, 1, 0, 0, 0, 3'd1, 1, 0, 1, 0, 0);
        step("ri_reset",    1, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);
        step("ri_after",    0, 1, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
